hbus_target: RTL

- Synthesizable HyperBus follower (target) that answers a HyperBus leader from the other end of the bus.
- Oversamples the bus on one fast system clock.
- Decodes the 48-bit command/address, counts initial latency, and services linear (optionally wrapped) read and write bursts against an internal 16-bit-word memory plus a small register space.
- Used for FPGA loopback and bench verification of the leader.

---
 rtl/hbus_target_if.sv | 24 ++
 rtl/hbus_target.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hbus_target_if.sv
// hbus_target_if: HyperBus pin bundle between a leader (master) and a target (slave).
// Ports: hbus_clk, hbus_csn, hbus_rstn, hbus_dq_i and hbus_rwds_i come from the leader.
//        hbus_dq_o/hbus_dq_oe and hbus_rwds_o/hbus_rwds_oe are driven by the target.
interface hbus_target_if #(
    parameter int WIDTH = 8
);
    logic             hbus_clk;
    logic             hbus_csn;
    logic             hbus_rstn;
    logic [WIDTH-1:0] hbus_dq_i;
    logic [WIDTH-1:0] hbus_dq_o;
    logic             hbus_dq_oe;
    logic             hbus_rwds_i;
    logic             hbus_rwds_o;
    logic             hbus_rwds_oe;
    modport master (
        output hbus_clk, hbus_csn, hbus_rstn, hbus_dq_i, hbus_rwds_i,
        input  hbus_dq_o, hbus_dq_oe, hbus_rwds_o, hbus_rwds_oe
    );
    modport slave (
        input  hbus_clk, hbus_csn, hbus_rstn, hbus_dq_i, hbus_rwds_i,
        output hbus_dq_o, hbus_dq_oe, hbus_rwds_o, hbus_rwds_oe
    );
endinterface

// File: rtl/hbus_target.sv
// hbus_target: oversampling HyperBus follower with a 16-bit word memory and ID0/CR0 registers.
// Ports: clk / rstn       system clock (>= 4x hbus_clk) and async active-low reset.
//        hbus (slave)     HyperBus pins: clock, chip select, bus reset, DQ and RWDS.
//        ca_o / ca_valid  last command/address and its one-clk update pulse.
//        busy             high whenever the target is not IDLE.
// Option: define HBUS_TGT_WRAP_EN so bursts with ca[45]=0 wrap within aligned 16-word groups.
module hbus_target #(
    parameter int               WIDTH          = 8,
    parameter int               MEM_ADDR_BITS  = 10,
    parameter int               TACC_COUNT     = 6,
    parameter bit               DOUBLE_LATENCY = 1'b1,
    parameter int               SYNC_STAGES    = 2,
    parameter logic [2*WIDTH-1:0] ID0_VALUE    = 16'h0C81,
    parameter logic [2*WIDTH-1:0] CR0_RESET    = 16'h8F1F
) (
    input  logic          clk,
    input  logic          rstn,
    hbus_target_if.slave  hbus,
    output logic [47:0]   ca_o,
    output logic          ca_valid,
    output logic          busy
);
    localparam int W   = 2 * WIDTH;
    localparam int SW  = WIDTH + 4;
    localparam int AW  = MEM_ADDR_BITS;
    localparam int NB  = 48 / WIDTH;
    localparam int LAT = TACC_COUNT * (DOUBLE_LATENCY ? 2 : 1);
    localparam int LW  = $clog2(LAT + 2);
    // Synchronizers come out of reset with the bus deselected and not in reset.
    localparam logic [SW-1:0] SYNC_RST = {2'b11, {(WIDTH + 2){1'b0}}};
    typedef enum logic [2:0] {IDLE, CA, LATENCY, WRITE, READ, WAIT_CS} state_t;
    logic [SW-1:0]       sync_q [SYNC_STAGES];
    logic                s_rstn, s_csn, s_clk, s_rwds, clk_prev_q, rise, fall;
    logic [WIDTH-1:0]    s_dq;
    state_t              state_q, state_d;
    logic [47-WIDTH:0]   sr_q, sr_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [LW-1:0]       lat_q, lat_d;
    logic [AW-1:0]       addr_q, addr_d, addr_inc;
    logic [WIDTH-1:0]    hi_q, hi_d, dq_o_q, dq_o_d;
    logic                hi_m_q, hi_m_d, hi_v_q, hi_v_d;
    logic [W-1:0]        cr0_q, cr0_d, rdata;
    logic                dq_oe_q, dq_oe_d, rwds_o_q, rwds_o_d, rwds_oe_q, rwds_oe_d;
    logic [47:0]         ca_q, ca_d, ca_w;
    logic                ca_valid_q, ca_valid_d, data_rise, data_fall, we_hi, we_lo;
    logic [W-1:0]        mem [2**AW];
    assign {s_rstn, s_csn, s_clk, s_rwds, s_dq} = sync_q[SYNC_STAGES-1];
    assign rise = s_clk & ~clk_prev_q;
    assign fall = ~s_clk & clk_prev_q;
    assign ca_w = {sr_q, s_dq};
    // The rise at latency count 0 is the first data rise, not a latency rise.
    assign data_rise = rise && (state_q == READ || state_q == WRITE || (state_q == LATENCY && lat_q == '0));
    assign data_fall = fall && (state_q == READ || state_q == WRITE);
    assign rdata = !ca_q[46] ? mem[addr_q] : addr_q == '0 ? ID0_VALUE : addr_q == AW'(1) ? cr0_q : '0;
`ifdef HBUS_TGT_WRAP_EN
    assign addr_inc = ca_q[45] ? addr_q + AW'(1) : {addr_q[AW-1:4], addr_q[3:0] + 4'd1};
`else
    assign addr_inc = addr_q + AW'(1);
`endif
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
            clk_prev_q <= 1'b0;
        end else begin
            sync_q[0] <= {hbus.hbus_rstn, hbus.hbus_csn, hbus.hbus_clk, hbus.hbus_rwds_i, hbus.hbus_dq_i};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            clk_prev_q <= s_clk;
        end
    end
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        addr_d     = addr_q;
        hi_d       = hi_q;
        hi_m_d     = hi_m_q;
        hi_v_d     = hi_v_q;
        cr0_d      = cr0_q;
        dq_o_d     = dq_o_q;
        dq_oe_d    = dq_oe_q;
        rwds_o_d   = rwds_o_q;
        rwds_oe_d  = rwds_oe_q;
        ca_d       = ca_q;
        ca_valid_d = 1'b0;
        we_hi      = 1'b0;
        we_lo      = 1'b0;
        case (state_q)
            IDLE: if (!s_csn) begin
                state_d   = CA;
                cnt_d     = '0;
                rwds_oe_d = 1'b1;
                rwds_o_d  = DOUBLE_LATENCY;
            end
            CA: if (rise || fall) begin
                sr_d  = {sr_q[47-2*WIDTH:0], s_dq};
                cnt_d = cnt_q + 3'd1;
                if (fall && cnt_q == 3'(NB - 1)) begin
                    ca_d       = ca_w;
                    ca_valid_d = 1'b1;
                    rwds_oe_d  = 1'b0;
                    lat_d      = LW'(LAT);
                    addr_d     = {ca_w[AW+12:16], ca_w[2:0]};
                    state_d    = (!ca_w[47] && ca_w[46]) ? WRITE : LATENCY;
                end
            end
            LATENCY: if (rise) begin
                lat_d = lat_q - LW'(1);
                if (lat_q == '0) state_d = ca_q[47] ? READ : WRITE;
            end
            default: ;
        endcase
        if (ca_q[47]) begin
            if (data_rise) begin
                dq_o_d    = rdata[W-1:WIDTH];
                rwds_o_d  = 1'b1;
                dq_oe_d   = 1'b1;
                rwds_oe_d = 1'b1;
            end
            if (data_fall) begin
                dq_o_d   = rdata[WIDTH-1:0];
                rwds_o_d = 1'b0;
                addr_d   = addr_inc;
            end
        end else begin
            if (data_rise) begin
                hi_d   = s_dq;
                hi_m_d = s_rwds;
                hi_v_d = 1'b1;
            end
            // A fall only commits once its matching rise byte has been captured.
            if (data_fall && hi_v_q) begin
                hi_v_d = 1'b0;
                addr_d = addr_inc;
                we_hi  = !ca_q[46] && !hi_m_q;
                we_lo  = !ca_q[46] && !s_rwds;
                if (ca_q[46] && addr_q == AW'(1))
                    cr0_d = {hi_m_q ? cr0_q[W-1:WIDTH] : hi_q, s_rwds ? cr0_q[WIDTH-1:0] : s_dq};
            end
        end
        // Deselect overrides state but leaves a same-cycle commit intact.
        if (s_csn) begin
            state_d   = IDLE;
            dq_oe_d   = 1'b0;
            rwds_oe_d = 1'b0;
            hi_v_d    = 1'b0;
        end
        if (!s_rstn) begin
            state_d    = IDLE;
            dq_o_d     = '0;
            dq_oe_d    = 1'b0;
            rwds_o_d   = 1'b0;
            rwds_oe_d  = 1'b0;
            ca_d       = '0;
            ca_valid_d = 1'b0;
            cr0_d      = CR0_RESET;
            hi_v_d     = 1'b0;
            we_hi      = 1'b0;
            we_lo      = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            lat_q      <= '0;
            addr_q     <= '0;
            hi_q       <= '0;
            hi_m_q     <= 1'b0;
            hi_v_q     <= 1'b0;
            cr0_q      <= CR0_RESET;
            dq_o_q     <= '0;
            dq_oe_q    <= 1'b0;
            rwds_o_q   <= 1'b0;
            rwds_oe_q  <= 1'b0;
            ca_q       <= '0;
            ca_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            addr_q     <= addr_d;
            hi_q       <= hi_d;
            hi_m_q     <= hi_m_d;
            hi_v_q     <= hi_v_d;
            cr0_q      <= cr0_d;
            dq_o_q     <= dq_o_d;
            dq_oe_q    <= dq_oe_d;
            rwds_o_q   <= rwds_o_d;
            rwds_oe_q  <= rwds_oe_d;
            ca_q       <= ca_d;
            ca_valid_q <= ca_valid_d;
        end
    end
    always_ff @(posedge clk) begin
        if (we_hi) mem[addr_q][W-1:WIDTH] <= hi_q;
        if (we_lo) mem[addr_q][WIDTH-1:0] <= s_dq;
    end
    assign hbus.hbus_dq_o     = dq_o_q;
    assign hbus.hbus_dq_oe    = dq_oe_q;
    assign hbus.hbus_rwds_o   = rwds_o_q;
    assign hbus.hbus_rwds_oe  = rwds_oe_q;
    assign ca_o               = ca_q;
    assign ca_valid           = ca_valid_q;
    assign busy               = state_q != IDLE;
endmodule
